opb_register_bank_ppc2simulink: RTL and testbench

Parametrised successor to the single software register. A bank of C_NUM_REGS 32-bit PPC-writable registers sits behind one OPB slave decode. The block provides byte-lane writes, readback, a per-register update strobe and an optional per-register auto-clear (pulse) mode. It runs entirely in the OPB clock domain; consumers in other domains add their own synchronisers.

---
 rtl/opb_register_bank_ppc2simulink.sv | 92 +++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// opb_register_bank_ppc2simulink: bank of PPC-writable 32-bit registers behind one OPB slave decode,
// with byte-lane writes, readback, per-register update strobes and optional auto-clear registers.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01040000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010400FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [63:0] C_PULSE_MASK = 64'd0,
    parameter logic [31:0] C_INIT_VALUE = 32'h00000000
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:3]                  OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:31]                 Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]    user_data_out,
    output logic [C_NUM_REGS-1:0]       user_update
);
    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
    state_t                  r_state;
    logic [31:0]             r_reg [C_NUM_REGS];
    logic [31:0]             r_dbus;
    logic                    r_ack;
    logic [C_NUM_REGS-1:0]   r_upd;
    logic [31:0]             w_addr, w_idx, w_wdata, w_mask, w_rdata;
    logic                    w_hit, w_valid;

    assign w_addr  = OPB_ABus;
    assign w_wdata = OPB_DBus;
    assign w_hit   = OPB_select && w_addr >= C_BASEADDR && w_addr <= C_HIGHADDR;
    assign w_idx   = (w_addr - C_BASEADDR) >> 2;
    assign w_valid = w_idx < C_NUM_REGS;
    // OPB_BE[0] is the most significant byte lane
    assign w_mask  = {{8{OPB_BE[0]}}, {8{OPB_BE[1]}}, {8{OPB_BE[2]}}, {8{OPB_BE[3]}}};

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < C_NUM_REGS; k++)
            if (w_idx == 32'(k)) w_rdata = r_reg[k];
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_dbus  <= '0;
            r_upd   <= '0;
            for (int k = 0; k < C_NUM_REGS; k++) r_reg[k] <= C_INIT_VALUE;
        end else begin
            r_ack  <= 1'b0;
            r_dbus <= '0;
            r_upd  <= '0;
            // auto-clear registers drop back to zero one cycle after their write
            for (int k = 0; k < C_NUM_REGS; k++)
                if (C_PULSE_MASK[k]) r_reg[k] <= '0;
            case (r_state)
                IDLE: if (w_hit) begin
                    r_state <= ACK;
                    r_ack   <= 1'b1;
                    r_dbus  <= (OPB_RNW && w_valid) ? w_rdata : '0;
                    for (int k = 0; k < C_NUM_REGS; k++)
                        if (!OPB_RNW && w_idx == 32'(k)) begin
                            r_reg[k] <= (r_reg[k] & ~w_mask) | (w_wdata & w_mask);
                            r_upd[k] <= 1'b1;
                        end
                end
                ACK:     r_state <= OPB_select ? WAIT : IDLE;
                default: r_state <= OPB_select ? WAIT : IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = r_reg[g];
    end

    assign user_update = r_upd;
    assign Sl_DBus     = r_dbus;
    assign Sl_xferAck  = r_ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = OPB_seqAddr & 1'b0;
endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb_opb_register_bank_ppc2simulink: directed OPB transfers checked every cycle against a
// transaction-level model of the register bank, plus literal spot checks.
module tb_opb_register_bank_ppc2simulink;
    localparam logic [31:0] BASE  = 32'h01040000;
    localparam logic [31:0] HIGH  = 32'h010400FF;
    localparam logic [3:0]  PMASK = 4'b0010;

    logic          OPB_Clk = 1'b0, OPB_Rst = 1'b1;
    logic [0:31]   OPB_ABus = '0, OPB_DBus = '0;
    logic [0:3]    OPB_BE = '0;
    logic          OPB_RNW = 1'b0, OPB_select = 1'b0, OPB_seqAddr = 1'b0;
    logic [0:31]   Sl_DBus;
    logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [127:0]  user_data_out;
    logic [3:0]    user_update;

    always #5 OPB_Clk = ~OPB_Clk;

    opb_register_bank_ppc2simulink #(.C_PULSE_MASK(64'(PMASK))) dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
        .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
        .Sl_toutSup(Sl_toutSup), .user_data_out(user_data_out), .user_update(user_update)
    );

    int           cyc = 0, n_cmp = 0, n_bad = 0, ack_cyc = -1, ovr_reg = -1;
    logic [31:0]  m_reg [4] = '{default: 32'h0};
    logic [31:0]  ack_dbus = '0, ovr_val = '0;
    logic [3:0]   ack_upd = '0;
    logic [127:0] e_data;
    bit           e_ack;

    always @(posedge OPB_Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // transaction model: one transfer that hit the decode is acked in the cycle after its sampling edge
    task automatic model(input logic [31:0] addr, input logic [0:3] be, input logic [31:0] d, input bit rnw);
        int i;
        logic [31:0] nv;
        ovr_reg = -1;
        if (addr < BASE || addr > HIGH) return;
        ack_cyc = cyc;
        i = int'((addr - BASE) >> 2);
        ack_upd = (i < 4 && !rnw) ? 4'(1 << i) : 4'b0;
        ack_dbus = (i < 4 && rnw) ? m_reg[i] : 32'h0;
        if (i < 4 && !rnw) begin
            nv = m_reg[i];
            for (int j = 0; j < 4; j++)
                if (be[j]) nv = (nv & ~(32'hFF << (24 - 8*j))) | (d & (32'hFF << (24 - 8*j)));
            if (PMASK[i]) begin ovr_reg = i; ovr_val = nv; end
            else m_reg[i] = nv;
        end
    endtask

    always @(negedge OPB_Clk) if (cyc > 0) begin
        e_ack = (cyc == ack_cyc);
        for (int k = 0; k < 4; k++) e_data[32*k +: 32] = (e_ack && ovr_reg == k) ? ovr_val : m_reg[k];
        chk("ack", 128'(Sl_xferAck), 128'(e_ack));
        chk("dbus", 128'(Sl_DBus), e_ack ? 128'(ack_dbus) : 128'h0);
        chk("update", 128'(user_update), e_ack ? 128'(ack_upd) : 128'h0);
        chk("data", user_data_out, e_data);
        chk("tied", 128'({Sl_errAck, Sl_retry, Sl_toutSup}), 128'h0);
    end

    task automatic xfer(input logic [31:0] addr, input logic [0:3] be, input logic [31:0] d,
                        input bit rnw, input int hold, output logic ak, output logic [31:0] rd,
                        output logic [3:0] upd, output logic [127:0] ud);
        @(posedge OPB_Clk); #2;
        OPB_ABus = addr; OPB_BE = be; OPB_DBus = d; OPB_RNW = rnw; OPB_select = 1'b1;
        @(posedge OPB_Clk); #1;
        model(addr, be, d, rnw);
        ak = Sl_xferAck; rd = Sl_DBus; upd = user_update; ud = user_data_out;
        for (int i = 1; i < hold; i++) @(posedge OPB_Clk);
        #1 OPB_select = 1'b0;
    endtask

    logic         ak;
    logic [31:0]  rd;
    logic [3:0]   upd;
    logic [127:0] ud;
    int           n_ack;

    initial begin
        repeat (2) @(posedge OPB_Clk);
        #2 OPB_Rst = 1'b0;
        chk("reset_data", user_data_out, 128'h0);
        // full write, select held three cycles
        xfer(BASE + 8, 4'b1111, 32'hDEADBEEF, 1'b0, 3, ak, rd, upd, ud);
        chk("full_ack", 128'(ak), 128'h1);
        chk("full_data", 128'(ud[95:64]), 128'hDEADBEEF);
        chk("full_upd", 128'(upd), 128'h4);
        xfer(BASE + 8, 4'b0000, 32'h0, 1'b1, 1, ak, rd, upd, ud);
        chk("full_read", 128'(rd), 128'hDEADBEEF);
        // byte-lane write
        xfer(BASE, 4'b1111, 32'h11223344, 1'b0, 1, ak, rd, upd, ud);
        xfer(BASE, 4'b0101, 32'hAABBCCDD, 1'b0, 2, ak, rd, upd, ud);
        chk("lane_data", 128'(ud[31:0]), 128'h11BB33DD);
        chk("lane_upd", 128'(upd), 128'h1);
        xfer(BASE + 1, 4'b0000, 32'h0, 1'b1, 1, ak, rd, upd, ud);
        chk("lane_read", 128'(rd), 128'h11BB33DD);
        // empty byte enables still strobe; low address bits ignored
        xfer(BASE + 32'h0E, 4'b0011, 32'h0000A5A5, 1'b0, 1, ak, rd, upd, ud);
        xfer(BASE + 12, 4'b0000, 32'hFFFFFFFF, 1'b0, 1, ak, rd, upd, ud);
        chk("be0_upd", 128'(upd), 128'h8);
        chk("be0_data", 128'(ud[127:96]), 128'h0000A5A5);
        // out-of-range index inside the decode window
        xfer(BASE + 32'h20, 4'b1111, 32'hCAFEF00D, 1'b0, 1, ak, rd, upd, ud);
        chk("oor_ack", 128'(ak), 128'h1);
        chk("oor_upd", 128'(upd), 128'h0);
        xfer(BASE + 32'h20, 4'b1111, 32'h0, 1'b1, 1, ak, rd, upd, ud);
        chk("oor_read", 128'(rd), 128'h0);
        // auto-clear register 1
        xfer(BASE + 4, 4'b1111, 32'h5, 1'b0, 1, ak, rd, upd, ud);
        chk("pulse_data", 128'(ud[63:32]), 128'h5);
        chk("pulse_upd", 128'(upd), 128'h2);
        @(posedge OPB_Clk); #1;
        chk("pulse_clear", 128'(user_data_out[63:32]), 128'h0);
        xfer(BASE + 4, 4'b1111, 32'h0, 1'b1, 1, ak, rd, upd, ud);
        chk("pulse_read", 128'(rd), 128'h0);
        // decode miss: never acked
        @(posedge OPB_Clk); #2;
        OPB_ABus = HIGH + 4; OPB_RNW = 1'b1; OPB_select = 1'b1; n_ack = 0;
        repeat (16) begin @(posedge OPB_Clk); #1 n_ack += int'(Sl_xferAck); end
        chk("miss_acks", 128'(n_ack), 128'h0);
        OPB_select = 1'b0;
        // reset in the ACK cycle of a write
        @(posedge OPB_Clk); #2;
        OPB_ABus = BASE + 8; OPB_BE = 4'b1111; OPB_DBus = 32'h12345678; OPB_RNW = 1'b0; OPB_select = 1'b1;
        @(posedge OPB_Clk); #1;
        model(BASE + 8, 4'b1111, 32'h12345678, 1'b0);
        chk("prerst_ack", 128'(Sl_xferAck), 128'h1);
        #5;
        OPB_Rst = 1'b1; OPB_select = 1'b0; ack_cyc = -1; ovr_reg = -1;
        for (int k = 0; k < 4; k++) m_reg[k] = 32'h0;
        #1;
        chk("rst_ack", 128'(Sl_xferAck), 128'h0);
        chk("rst_data", user_data_out, 128'h0);
        repeat (2) @(posedge OPB_Clk);
        #2 OPB_Rst = 1'b0;
        xfer(BASE + 8, 4'b1111, 32'h0F0F0F0F, 1'b0, 1, ak, rd, upd, ud);
        chk("post_ack", 128'(ak), 128'h1);
        chk("post_data", 128'(ud[95:64]), 128'h0F0F0F0F);
        repeat (3) @(posedge OPB_Clk);
        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
